// File: rtl/md5_pkg.sv
// md5_pkg
// Shared definitions for the MD5 block loader: the loader FSM state
// encoding, MD5 block geometry constants and a helper that forms the
// message-length word (length in bits) for a single-block message.
package md5_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    DROP,
    PAD,
    WAIT_UNIT,
    WRITE,
    START
  } loader_state_t;

  localparam int MD5_BLOCK_WORDS = 16;
  localparam int MD5_LEN_WORD = 14;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
  localparam int MD5_MAX_SINGLE_BYTES = 55;

  // A single-block message is at most 55 bytes, so its bit length always
  // fits in the low 32-bit length word.
  function automatic logic [31:0] md5_len_bits(input logic [5:0] nbytes);
    return {23'd0, nbytes, 3'd0};
  endfunction

endpackage

// File: rtl/md5_unit_tracker.sv
// md5_unit_tracker
// Keeps a busy flag per md5unit and picks the unit a new message should
// go to.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset, clears both busy flags
//   done[1:0]  md5unit done levels, bit u = unit u
//   start[1:0] loader start pulses, bit u = unit u
//   busy[1:0]  unit u is working on a block
//   free_unit  unit to try next (only meaningful with busy[free_unit]=0)
//
// Build option: MD5_LOADER_DUAL_UNIT_EN selects between both units; without
// it the select is tied to unit 0 and unit 1 is never started.
module md5_unit_tracker
  import md5_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] done,
  input  logic [1:0] start,
  output logic [1:0] busy,
  output logic       free_unit
);

  logic [1:0] done_q;
  logic [1:0] done_rise;

  assign done_rise = done & ~done_q;

  // A unit clears on the rising edge of its done. The start term is OR-ed
  // last, so a done edge landing in that unit's start cycle is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 2'b00;
      busy   <= 2'b00;
    end else begin
      done_q <= done;
      busy   <= start | (busy & ~done_rise);
    end
  end

`ifdef MD5_LOADER_DUAL_UNIT_EN
  // Prefer unit 0; fall over to unit 1 only while unit 0 is occupied.
  assign free_unit = busy[0];
`else
  assign free_unit = 1'b0;
`endif

endmodule

// File: rtl/md5_block_loader.sv
// md5_block_loader
// Collects a byte stream into one MD5 block, appends the 0x80 pad byte and
// the bit-length word, then writes the 16 little-endian words into a free
// md5unit and pulses its start bit. Messages longer than MAX_MSG_BYTES are
// swallowed and reported with len_err.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready   byte stream, transfer on valid&&ready
//   done[1:0]         md5unit done levels
//   write/writeaddr/writedata           md5unit word write port,
//                                       writeaddr = {unit, word index}
//   start[1:0]        one-cycle start pulse per unit
//   job_valid/job_unit  dispatch pulse and the unit that got the block
//   len_err           one-cycle pulse after an overlong message is dropped
//
// Build option: MD5_LOADER_DUAL_UNIT_EN enables dispatch to two units;
// by default only unit 0 is used.
module md5_block_loader
  import md5_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [1:0]  done,
  output logic        write,
  output logic [4:0]  writeaddr,
  output logic [31:0] writedata,
  output logic [1:0]  start,
  output logic        job_valid,
  output logic        job_unit,
  output logic        len_err
);

  loader_state_t state, next_state;

  logic [31:0] block_words [0:MD5_BLOCK_WORDS-1];
  logic [5:0]  count;
  logic [5:0]  count_inc;
  logic [4:0]  byte_lsb;
  logic [3:0]  word_idx;
  logic        unit_sel;
  logic        ready_en;
  logic        len_err_q;
  logic        take;
  logic [1:0]  unit_busy;
  logic        free_unit;
  logic        unit_free;

  md5_unit_tracker u_tracker (
    .clk       (clk),
    .rst_n     (reset),
    .done      (done),
    .start     (start),
    .busy      (unit_busy),
    .free_unit (free_unit)
  );

  // ready_en keeps in_ready low while reset is held, since the state
  // register already sits in COLLECT during reset.
  assign in_ready  = ready_en && (state == COLLECT || state == DROP);
  assign take      = in_valid && in_ready;
  assign count_inc = count + 6'd1;
  assign byte_lsb  = {count[1:0], 3'b000};
  assign unit_free = !unit_busy[free_unit];
  assign len_err   = len_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    write      = 1'b0;
    writeaddr  = 5'd0;
    writedata  = 32'd0;
    start      = 2'b00;
    job_valid  = 1'b0;
    job_unit   = 1'b0;
    case (state)
      COLLECT: begin
        if (take) begin
          if (in_last) begin
            next_state = PAD;
          end else if (count_inc == 6'(MAX_MSG_BYTES)) begin
            next_state = DROP;
          end
        end
      end
      DROP: begin
        if (take && in_last) begin
          next_state = COLLECT;
        end
      end
      PAD: begin
        next_state = WAIT_UNIT;
      end
      WAIT_UNIT: begin
        if (unit_free) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        write     = 1'b1;
        writeaddr = {unit_sel, word_idx};
        writedata = block_words[word_idx];
        if (word_idx == 4'd15) begin
          next_state = START;
        end
      end
      START: begin
        job_valid = 1'b1;
`ifdef MD5_LOADER_DUAL_UNIT_EN
        start    = unit_sel ? 2'b10 : 2'b01;
        job_unit = unit_sel;
`else
        start    = 2'b01;
`endif
        next_state = COLLECT;
      end
      default: begin
        next_state = COLLECT;
      end
    endcase
  end

  // Block buffer and sequencing counters. The buffer is zeroed after every
  // dispatch or drop, so PAD only has to place the 0x80 byte and the length
  // word; the bytes after the pad byte are already zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MD5_BLOCK_WORDS; i++) begin
        block_words[i] <= 32'd0;
      end
      count     <= 6'd0;
      word_idx  <= 4'd0;
      unit_sel  <= 1'b0;
      ready_en  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      len_err_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (take) begin
            block_words[count[5:2]][byte_lsb +: 8] <= in_data;
            count <= count_inc;
          end
        end
        DROP: begin
          if (take && in_last) begin
            len_err_q <= 1'b1;
            count     <= 6'd0;
            for (int i = 0; i < MD5_BLOCK_WORDS; i++) begin
              block_words[i] <= 32'd0;
            end
          end
        end
        PAD: begin
          block_words[count[5:2]][byte_lsb +: 8] <= MD5_PAD_BYTE;
          block_words[MD5_LEN_WORD]              <= md5_len_bits(count);
          block_words[MD5_BLOCK_WORDS-1]         <= 32'd0;
        end
        WAIT_UNIT: begin
          if (unit_free) begin
            unit_sel <= free_unit;
            word_idx <= 4'd0;
          end
        end
        WRITE: begin
          word_idx <= word_idx + 4'd1;
        end
        START: begin
          count <= 6'd0;
          for (int i = 0; i < MD5_BLOCK_WORDS; i++) begin
            block_words[i] <= 32'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/md5_block_loader.md
Name: md5_block_loader

Overview:
- Upstream feeder for md5unit: accepts a byte stream, applies MD5 padding and the length field, and produces one 512-bit block per message.
- Writes the block as 16 little-endian 32-bit words over md5unit's write/writeaddr/writedata port, then pulses that unit's start bit.
- Tracks which of the two hash units is busy and dispatches each message to a free unit.
- Single-block messages only: 1..MAX_MSG_BYTES bytes.

Parameters:
- MAX_MSG_BYTES, 55: longest accepted message in bytes; legal range 1..55.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  byte present
- in_data  in  8  message byte
- in_last  in  1  final byte of message
- in_ready  out  1  loader accepts byte this cycle
- done  in  2  md5unit done, bit u = unit u
- write  out  1  md5unit word write strobe
- writeaddr  out  5  {unit, word index 0..15}
- writedata  out  32  block word
- start  out  2  one-cycle start pulse per unit
- job_valid  out  1  one-cycle pulse when a message is dispatched
- job_unit  out  1  unit that received it; valid with job_valid
- len_err  out  1  one-cycle pulse when an overlong message is dropped

Behaviour:
- Reset (asserted low) value of all outputs is 0; in_ready=0. Block buffer, byte count, busy[1:0] and the FSM are cleared; FSM enters COLLECT.
- Reset mid-operation: any write burst is abandoned with no start pulse, and both units are treated as free.
- Byte transfer occurs when in_valid && in_ready.
- Byte n goes to buffer word n/4, bits [8*(n%4)+7 : 8*(n%4)]. Little-endian within each word.
- COLLECT: in_ready=1.
  - On a transfer with in_last=1 and count+1 <= MAX_MSG_BYTES: go to PAD.
  - If count reaches MAX_MSG_BYTES without in_last: go to DROP.
- DROP: in_ready=1; bytes are discarded. On in_last: pulse len_err, clear count and buffer, return to COLLECT. No dispatch.
- PAD (1 cycle), for a message of L bytes:
  - Byte L = 0x80; bytes L+1..55 = 0x00.
  - Word 14 = L*8 (32-bit); word 15 = 0.
  - in_ready=0. Go to WAIT_UNIT.
- WAIT_UNIT: in_ready=0. Select unit 0 if !busy[0], else unit 1 if !busy[1], else stay. The selected unit is latched.
- WRITE: 16 consecutive cycles with write=1, writeaddr={unit, idx}, writedata=buf[idx], idx = 0..15 ascending.
- START: 1 cycle.
  - start[unit]=1, job_valid=1, job_unit=unit; busy[unit] set.
  - Buffer and count cleared; next cycle is COLLECT.
- busy[u] clears on a rising edge of done[u] (done registered one cycle for edge detection).
  - Edges seen during the START cycle of unit u are ignored.
  - Set and clear in the same cycle: set wins.
- Latency, from the transfer of the final byte with a free unit available:
  - PAD is the next cycle; WAIT_UNIT follows.
  - First write occurs 3 cycles after the final byte; start occurs 19 cycles after it.
- Messages queue upstream through in_ready=0; there is no internal FIFO beyond the single block buffer.

Optional Feature:
- Macro MD5_LOADER_DUAL_UNIT_EN.
- Defined: two-unit dispatch as described above.
- Undefined:
  - Only unit 0 is used; writeaddr[4]=0, start[1]=0, job_unit=0.
  - busy[1] and done[1] are ignored.
  - WAIT_UNIT waits for !busy[0].

Decomposition:
- Package md5_pkg holds:
  - FSM state enum (COLLECT, DROP, PAD, WAIT_UNIT, WRITE, START).
  - Constants MD5_BLOCK_WORDS=16, MD5_LEN_WORD=14, MD5_PAD_BYTE=8'h80, MD5_MAX_SINGLE_BYTES=55.
- One natural sub-module: md5_unit_tracker. It takes done and start and produces busy[1:0] plus the free-unit select, covering edge detection and set/clear priority.

Test Plan:
- 42-byte message, bytes 08 02 68 01 bb 80 ab 13 ... 33 85 (packing to words 01680208, 13ab80bb, cb8b2c30, b9657582, a3793c48, 103f26be, 0b78dac4, 5c433348, 4de99287, eff0be7c, then bytes 33 85 for word 10) -> 16 writes to unit 0 with word10=00808533, words 11-13=0, word14=00000150, word15=0; start=2'b01; job_valid with job_unit=0. Driving md5unit yields digest0=baebddf861d3eb2714ba892c2ad26682.
- 1-byte message 0x61 -> word0=00008061, word14=00000008, all others 0.
- 55-byte message -> byte 55=0x80 (word13=0x80xxxxxx), word14=000001b8. 56-byte message -> no writes, len_err pulse after in_last, next message processed normally.
- Two back-to-back messages while done=0 -> first to unit 0 (writeaddr 0x00-0x0f), second to unit 1 (0x10-0x1f). A third stalls with in_ready=0 until done[0] rises, then dispatches to unit 0.
- Reset asserted at word 7 of the write burst -> write/start drop to 0 asynchronously, busy cleared. After release, a new message dispatches to unit 0.
- Without MD5_LOADER_DUAL_UNIT_EN: two messages -> second waits for the done[0] rise, and writeaddr[4]=0 throughout.
